count_uart_tx: RTL and testbench

- Serial output stage placed directly downstream of the 8-bit counter.
- Accepts an 8-bit count snapshot through a valid/ready handshake.
- Transmits the snapshot on a single pin as a UART 8N1 frame: start bit, 8 data bits LSB-first, 1 stop bit.
- Lets the counter value be read off-chip with one wire instead of eight parallel outputs.

---
 rtl/count_uart_tx.sv | 106 ++++++++++
 tb/tb_count_uart_tx.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/count_uart_tx.sv
// UART 8N1 transmitter for an 8-bit count snapshot: start bit, 8 data bits LSB-first, one stop bit.
// Accepts a byte through a valid/ready handshake and drives it on a single idle-high line.
module count_uart_tx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       tx,
  output logic       busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

  generate
    if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 65535) begin : g_bad_clks_per_bit
      $error("count_uart_tx: CLKS_PER_BIT must lie in 2..65535");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;

  assign in_ready = (state == IDLE) && ena && rst_n;

  // NOTE: every register below is assigned with <= so all of them update from
  // the same pre-edge values; blocking = here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      tx      <= 1'b1;
      busy    <= 1'b0;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
    end else if (ena) begin
      unique case (state)
        IDLE: begin
          tx   <= 1'b1;
          busy <= 1'b0;
          if (in_valid) begin
            state <= START;
            tx    <= 1'b0;
            busy  <= 1'b1;
            cnt   <= '0;
            shift <= in_data;
          end
        end

        START: begin
          if (cnt == LAST_CNT) begin
            state   <= DATA;
            tx      <= shift[0];
            bit_idx <= '0;
            cnt     <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        DATA: begin
          if (cnt == LAST_CNT) begin
            cnt <= '0;
            if (bit_idx == 3'd7) begin
              state <= STOP;
              tx    <= 1'b1;
            end else begin
              // Next LSB is shift[1] because the shift lands on this same edge.
              shift   <= shift >> 1;
              tx      <= shift[1];
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        STOP: begin
          if (cnt == LAST_CNT) begin
            state <= IDLE;
            busy  <= 1'b0;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_count_uart_tx.sv
// Scoreboard bench for count_uart_tx: the driver queues each accepted byte with its expected
// frame length, and a receiver-style monitor decodes the serial line and compares.
module tb_count_uart_tx;

  localparam int C = 4;

  typedef struct {
    logic [7:0] data;
    int         wall;  // edges from transfer to return to idle
    int         gap;   // idle cycles before this frame starts, -1 = any
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       tx;
  logic       busy;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  count_uart_tx #(.CLKS_PER_BIT(C)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ena      (ena),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .tx       (tx),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Offer a byte, wait for the handshake, record what the line must carry,
  // then optionally freeze the block for drop_len edges starting drop_at edges later.
  task automatic send(input logic [7:0] d, input int drop_at, input int drop_len,
                      input bit keep_valid, input int gap);
    bit   hs = 1'b0;
    int   n = 0;
    exp_t e;
    in_data  = d;
    in_valid = 1'b1;
    while (!hs) begin
      @(negedge clk);
      hs = in_ready;
      @(posedge clk);
      #1;
      n++;
      if (!hs && n > 1000) begin
        check("handshake_timeout", 32'(n), 32'd0);
        in_valid = 1'b0;
        return;
      end
    end
    e.data = d;
    e.wall = 10 * C + ((drop_at >= 1) ? drop_len : 0);
    e.gap  = gap;
    exp_q.push_back(e);
    if (!keep_valid) in_valid = 1'b0;
    if (drop_at >= 1) begin
      repeat (drop_at - 1) @(posedge clk);
      #1 ena = 1'b0;
      repeat (drop_len) @(posedge clk);
      #1 ena = 1'b1;
    end
  endtask

  // Monitor state
  bit         in_frame = 1'b0;
  bit         mon_act;
  bit         mon_rst;
  int         act_cnt;
  int         wall;
  int         idle_cnt = 0;
  logic [7:0] rx;
  logic       prev_tx = 1'b1;
  exp_t       popped;

  initial begin : monitor
    forever begin
      @(posedge clk);
      mon_act = ena && rst_n;
      mon_rst = !rst_n;
      @(negedge clk);
      if (!rst_n) check("ready_in_reset", in_ready, 0);
      if (mon_rst) begin
        check("reset_tx", tx, 1);
        check("reset_busy", busy, 0);
        if (in_frame && exp_q.size() > 0) popped = exp_q.pop_front();
        in_frame = 1'b0;
        idle_cnt = 0;
      end else if (!in_frame) begin
        if (tx === 1'b0) begin
          check("start_on_enabled_edge", mon_act, 1);
          check("frame_expected", exp_q.size() > 0, 1);
          if (exp_q.size() > 0 && exp_q[0].gap >= 0)
            check("idle_gap", idle_cnt, exp_q[0].gap);
          check("busy_at_start", busy, 1);
          check("ready_at_start", in_ready, 0);
          in_frame = 1'b1;
          act_cnt  = 0;
          wall     = 0;
          rx       = '0;
        end else begin
          check("idle_tx", tx, 1);
          check("idle_busy", busy, 0);
          check("idle_ready", in_ready, ena && rst_n);
          idle_cnt++;
        end
      end else begin
        wall++;
        if (mon_act) begin
          act_cnt++;
          if (act_cnt < 10 * C && act_cnt % C == C / 2) begin
            if (act_cnt / C == 0) check("start_bit", tx, 0);
            else if (act_cnt / C == 9) check("stop_bit", tx, 1);
            else rx[act_cnt / C - 1] = tx;
          end
        end else begin
          check("hold_tx_disabled", tx, prev_tx);
        end
        if (act_cnt == 10 * C) begin
          check("end_busy", busy, 0);
          check("end_tx", tx, 1);
          check("end_ready", in_ready, ena && rst_n);
          check("frame_expected_at_end", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) begin
            popped = exp_q.pop_front();
            check("frame_data", rx, popped.data);
            check("frame_length", wall, popped.wall);
          end
          in_frame = 1'b0;
          idle_cnt = 0;
        end else begin
          check("frame_busy", busy, 1);
          check("frame_ready", in_ready, 0);
        end
      end
      prev_tx = tx;
    end
  end

  initial begin : driver
    rst_n    = 1'b0;
    ena      = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (50) @(posedge clk);
    #1;

    // Single frame
    send(8'hC5, -1, 0, 1'b0, -1);
    repeat (45) @(posedge clk);
    #1;

    // Back-to-back with valid held: second frame follows with no idle gap
    send(8'h00, -1, 0, 1'b1, -1);
    send(8'hFF, -1, 0, 1'b0, 0);
    repeat (45) @(posedge clk);
    #1;

    // Valid pulsed mid-frame with new data must be ignored
    send(8'h3C, -1, 0, 1'b0, -1);
    repeat (15) @(posedge clk);
    #1;
    in_data  = 8'hAA;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (60) @(posedge clk);
    #1;

    // Enable dropped for 7 cycles inside data bit 2
    send(8'h5A, 14, 7, 1'b0, -1);
    repeat (45) @(posedge clk);
    #1;

    // One-cycle reset inside data bit 5, then a clean frame
    send(8'h96, -1, 0, 1'b0, -1);
    repeat (25) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    send(8'h81, -1, 0, 1'b0, -1);
    repeat (45) @(posedge clk);
    #1;

    // Random bytes, spacing, held valid and enable gaps
    for (int i = 0; i < 12; i++) begin
      logic [7:0] d;
      d = 8'($urandom);
      repeat ($urandom_range(0, 6)) @(posedge clk);
      #1;
      if ($urandom_range(0, 1) == 1)
        send(d, int'($urandom_range(1, 10 * C)), int'($urandom_range(1, 6)),
             1'($urandom_range(0, 1)), -1);
      else
        send(d, -1, 0, 1'($urandom_range(0, 1)), -1);
    end
    in_valid = 1'b0;
    repeat (10 * C + 20) @(posedge clk);
    #1;

    check("queue_drained", exp_q.size(), 0);
    check("frame_closed", in_frame, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
